// File: rtl/ifm_frame_feeder.sv
// Serial-to-parallel IFM feeder: packs 32 4-bit samples into one frame, double-buffered.
// Optional FEEDER_PAD_EN: an aborting s_sof zero-pads and emits the partial frame.
module ifm_frame_feeder #(
  parameter int DATA_W = 4,
  parameter int LANES  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_sof,
  output logic                      s_ready,
  input  logic                      out_stall,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   out_ifm,
  output logic                      frame_err,
  output logic [CNT_W-1:0]          frame_cnt
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  logic [IDX_W-1:0]                r_idx;
  logic                            r_pend;
  logic [LANES-1:0][DATA_W-1:0]    r_collect;
  logic [LANES-1:0][DATA_W-1:0]    r_shadow;

  logic                            w_accept;
  logic                            w_abort;
  logic                            w_emit;
  logic                            w_load;
  logic [IDX_W-1:0]                w_lane;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic [LANES-1:0][DATA_W-1:0]    w_shadow_nxt;

  // Stall only blocks the sample that would need the occupied shadow buffer.
`ifdef FEEDER_PAD_EN
  assign s_ready = !(r_pend && out_stall && (r_idx != '0));
`else
  assign s_ready = !(r_pend && out_stall && (r_idx == LAST));
`endif

  always_comb begin
    w_accept     = s_valid && s_ready;
    w_abort      = w_accept && s_sof && (r_idx != '0);
    w_emit       = r_pend && !out_stall;
    w_lane       = s_sof ? '0 : r_idx;
    w_idx_nxt    = s_sof ? IDX_W'(1) : r_idx + 1'b1;
    w_load       = w_accept && !s_sof && (r_idx == LAST);
    w_shadow_nxt = r_collect;
    w_shadow_nxt[r_idx] = s_data;
`ifdef FEEDER_PAD_EN
    if (w_abort) begin
      w_load = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        w_shadow_nxt[k] = (IDX_W'(k) < r_idx) ? r_collect[k] : '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_pend    <= 1'b0;
      r_collect <= '0;
      r_shadow  <= '0;
      out_valid <= 1'b0;
      out_ifm   <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_collect[w_lane] <= s_data;
        r_idx             <= w_idx_nxt;
      end
      // A load in the same cycle as an emit keeps pend set (back-to-back frames).
      if (w_load) begin
        r_shadow <= w_shadow_nxt;
        r_pend   <= 1'b1;
      end else if (w_emit) begin
        r_pend <= 1'b0;
      end
      out_valid <= w_emit;
      frame_err <= w_abort;
      if (w_emit) begin
        out_ifm   <= r_shadow;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifm_frame_feeder.sv
// Self-checking bench for ifm_frame_feeder against a frame-level queue model.
module tb_ifm_frame_feeder;
  localparam int DW = 4;
  localparam int LN = 32;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DW-1:0]     s_data;
  logic              s_sof;
  logic              s_ready;
  logic              out_stall;
  logic              out_valid;
  logic [LN*DW-1:0]  out_ifm;
  logic              frame_err;
  logic [CW-1:0]     frame_cnt;

  always #5 clk = ~clk;

  ifm_frame_feeder #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
    .s_ready(s_ready), .out_stall(out_stall), .out_valid(out_valid),
    .out_ifm(out_ifm), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the frame in progress, one waiting frame, expected outputs.
  logic [DW-1:0]    m_cur[$];
  bit               m_pend;
  logic [LN*DW-1:0] m_shadow;
  logic             e_valid;
  logic [LN*DW-1:0] e_ifm;
  logic             e_err;
  logic [CW-1:0]    e_cnt;

  task automatic chk(input string tag, input logic [LN*DW-1:0] obs, input logic [LN*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur.delete();
    m_pend   = 1'b0;
    m_shadow = '0;
    e_valid  = 1'b0;
    e_ifm    = '0;
    e_err    = 1'b0;
    e_cnt    = '0;
  endtask

  function automatic bit model_ready(input bit stall);
`ifdef FEEDER_PAD_EN
    return !(m_pend && stall && m_cur.size() != 0);
`else
    return !(m_pend && stall && m_cur.size() == LN - 1);
`endif
  endfunction

  function automatic logic [LN*DW-1:0] pack_cur();
    logic [LN*DW-1:0] f = '0;
    for (int k = 0; k < m_cur.size(); k++) f[DW*k +: DW] = m_cur[k];
    return f;
  endfunction

  task automatic check_outputs();
    chk("out_valid", LN*DW'(out_valid), LN*DW'(e_valid));
    chk("frame_err", LN*DW'(frame_err), LN*DW'(e_err));
    chk("frame_cnt", LN*DW'(frame_cnt), LN*DW'(e_cnt));
    chk("out_ifm", out_ifm, e_ifm);
  endtask

  // One clock: drive inputs, check s_ready, advance the model, check outputs after the edge.
  task automatic tick(input bit v, input logic [DW-1:0] d, input bit sof, input bit stall, output bit acc);
    bit               r;
    bit               emit;
    bit               load;
    logic [LN*DW-1:0] f;
    s_valid   = v;
    s_data    = d;
    s_sof     = sof;
    out_stall = stall;
    r = model_ready(stall);
    #1;
    chk("s_ready", LN*DW'(s_ready), LN*DW'(r));
    acc  = v && r;
    emit = m_pend && !stall;
    load = 1'b0;
    f    = '0;
    e_valid = emit;
    if (emit) begin
      e_ifm = m_shadow;
      e_cnt = e_cnt + 1'b1;
    end
    e_err = acc && sof && (m_cur.size() != 0);
    if (acc) begin
      if (sof && m_cur.size() != 0) begin
`ifdef FEEDER_PAD_EN
        f    = pack_cur();
        load = 1'b1;
`endif
        m_cur.delete();
      end
      m_cur.push_back(d);
      if (m_cur.size() == LN) begin
        f    = pack_cur();
        load = 1'b1;
        m_cur.delete();
      end
    end
    if (load) begin
      m_pend   = 1'b1;
      m_shadow = f;
    end else if (emit) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [DW-1:0] d, input bit sof, input bit stall);
    bit acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) tick(1'b1, d, sof, stall, acc);
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int n;
    logic [DW-1:0] f2[LN];

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; out_stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_s_ready", LN*DW'(s_ready), LN*DW'(1));
    rst = 1'b0;

    // Ramp frame: lane k = k mod 16
    for (int k = 0; k < LN; k++) send(DW'(k % 16), k == 0, 1'b0);
    idle(4);

    // Three back-to-back random frames
    for (int k = 0; k < 3 * LN; k++) send(DW'($urandom), (k % LN) == 0, 1'b0);
    idle(4);

    // Frame 1, then frame 2 streams under a 40-cycle stall
    for (int k = 0; k < LN; k++) send(DW'($urandom), k == 0, 1'b0);
    for (int k = 0; k < LN; k++) f2[k] = DW'($urandom);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1'b1, f2[n], n == 0, 1'b1, acc);
      if (acc) n++;
    end
    while (n < LN) begin
      send(f2[n], n == 0, 1'b0);
      n++;
    end
    idle(4);

    // Abort: 10 samples, then s_sof 0xA + 31 x 0x5
    for (int k = 0; k < 10; k++) send(DW'(k + 1), k == 0, 1'b0);
    send(4'hA, 1'b1, 1'b0);
    for (int k = 1; k < LN; k++) send(4'h5, 1'b0, 1'b0);
    idle(4);

    // Async reset with a pending frame and idx=17
    for (int k = 0; k < LN; k++) send(DW'($urandom_range(1, 15)), k == 0, 1'b1);
    for (int k = 0; k < 17; k++) send(DW'($urandom), k == 0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_s_ready", LN*DW'(s_ready), LN*DW'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < LN; k++) send(DW'($urandom), k == 0, 1'b0);
    idle(4);

    // Random traffic: gaps, stalls and stray s_sof
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 3) != 0, DW'($urandom),
           (m_cur.size() == 0) || ($urandom_range(0, 39) == 0),
           $urandom_range(0, 3) == 0, acc);
    end
    idle(4);

    // Counter wrap (CNT_W=4)
    for (int k = 0; k < 18 * LN; k++) send(DW'($urandom), (k % LN) == 0, 1'b0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
